rv32i_if_stage: RTL and testbench
=================================

Name: rv32i_if_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register of the RV32I 5-stage pipeline; sits directly upstream of the Decoder/control_unit. Owns the PC, issues single-outstanding requests to instruction memory, and accepts EX-stage redirects (taken branch, jal, jalr). Holds its output under hazard stall and inserts a NOP bubble under flush. A one-entry skid buffer ensures no fetched instruction is lost.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven on if_id_instr when invalid

Ports:
clk  input  1  pipeline clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hazard stall from ID: hold IF/ID register and PC
flush  input  1  replace IF/ID contents with bubble next edge
redirect_valid  input  1  EX redirect (branch_taken or jump/jalr)
redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 00)
imem_req  output  1  fetch request, accepted in the cycle it is high
imem_addr  output  32  fetch address, word aligned, valid when imem_req=1
imem_rvalid  input  1  response strobe, >=1 cycle after request
imem_rdata  input  32  instruction word, valid with imem_rvalid
if_id_instr  output  32  instruction to ID
if_id_pc  output  32  PC of if_id_instr
if_id_pc_plus_4  output  32  if_id_pc + 4 (mod 2^32)
if_id_valid  output  1  1 = real instruction, 0 = bubble

Behaviour:
- Reset (async, active-high): pc_q=RESET_PC, state=IDLE, buf_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus_4=0, if_id_valid=0, imem_req=0. Reset mid-request: outstanding response is ignored (state IDLE, imem must not respond after reset).
- States: IDLE (nothing outstanding), WAIT (request outstanding), DROP (outstanding response belongs to a killed path).
- IDLE: if !redirect_valid && !buf_valid -> imem_req=1, imem_addr=pc_q, go WAIT. If redirect_valid -> pc_q<=redirect_pc & ~3, no request this cycle, stay IDLE. No request while buf_valid=1.
- WAIT, imem_rvalid=1, no redirect: if stall=0 and flush=0 and buf_valid=0 -> IF/ID loads {imem_rdata, pc_q, pc_q+4, valid=1}; otherwise word goes to skid buffer (buf_valid=1, buf_pc=pc_q). pc_q<=pc_q+4; go IDLE.
- WAIT, redirect_valid=1, no rvalid: pc_q<=redirect target, go DROP. Redirect and rvalid same cycle: discard word, pc_q<=target, go IDLE.
- DROP: on imem_rvalid discard word, go IDLE. Redirect in DROP: update pc_q, stay DROP (or IDLE if rvalid same cycle).
- Skid buffer: when buf_valid=1 and stall=0 and flush=0 -> IF/ID loads buffer, buf_valid<=0. redirect_valid clears buf_valid.
- IF/ID priority per edge: flush (bubble: instr=NOP_INSTR, valid=0, pc fields hold) > stall (hold all) > load from buffer > load from imem > hold.
- Minimum latency: request at edge N, rvalid in cycle N+1 -> if_id_valid=1 after edge N+1; sustained throughput one instruction per 2 cycles for 1-cycle memory.
- Arithmetic: all PC math 32-bit modulo; pc_q=32'hFFFF_FFFC advances to 32'h0000_0000, pc_plus_4 of FFFF_FFFC is 0.
- imem_addr[1:0] always 00.

Test Plan:
- Reset with RESET_PC=0, 1-cycle imem returning addr-indexed words -> if_id_pc sequence 0,4,8 with valid=1, instr matching mem[0],mem[1],mem[2]; all outputs at reset values while reset=1.
- stall held 3 cycles while response arrives -> IF/ID holds previous instr, word lands in buffer, no new imem_req; after stall drops next instruction appears with correct pc, none skipped or duplicated.
- Redirect to 32'h0000_0103 while WAIT (3-cycle imem) -> late response discarded, next imem_addr=32'h0000_0100, first valid if_id_pc=0x100.
- flush and redirect same cycle as rvalid -> if_id_valid=0, if_id_instr=32'h0000_0013 next edge, arriving word dropped, fetch resumes at target.
- pc_q=32'hFFFF_FFFC fetch -> if_id_pc_plus_4=0, next imem_addr=0.
- Assert reset while in WAIT -> outputs return to reset values immediately; first post-reset imem_addr=RESET_PC.

Source files
------------

// File: rtl/rv32i_if_stage.sv
// RV32I instruction-fetch stage with IF/ID pipeline register.
// Single outstanding imem request, EX redirects, stall/flush handling and a one-entry skid buffer.
module rv32i_if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus_4,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;

    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;

    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic [31:0] redirect_target;
    logic [31:0] pc_plus_4;
    logic [31:0] buf_pc_plus_4;
    logic        fetch_req;
    logic        word_live;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
    assign pc_plus_4       = pc_q + 32'd4;
    assign buf_pc_plus_4   = buf_pc_q + 32'd4;

    // Fetch FSM: word_live marks a response that belongs to the current path.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fetch_req = 1'b0;
        word_live = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end else if (!buf_valid_q) begin
                    fetch_req = 1'b1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = imem_rvalid ? IDLE : DROP;
                end else if (imem_rvalid) begin
                    word_live = 1'b1;
                    pc_d      = pc_plus_4;
                    state_d   = IDLE;
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
                if (imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // IF/ID register and skid buffer; flush beats stall, buffer beats memory.
    always_comb begin
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        buf_valid_d  = buf_valid_q;
        buf_instr_d  = buf_instr_q;
        buf_pc_d     = buf_pc_q;

        if (flush) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (!stall) begin
            if (buf_valid_q && !redirect_valid) begin
                ifid_instr_d = buf_instr_q;
                ifid_pc_d    = buf_pc_q;
                ifid_pc4_d   = buf_pc_plus_4;
                ifid_valid_d = 1'b1;
            end else if (word_live) begin
                ifid_instr_d = imem_rdata;
                ifid_pc_d    = pc_q;
                ifid_pc4_d   = pc_plus_4;
                ifid_valid_d = 1'b1;
            end
        end

        // A redirect makes any buffered younger instruction wrong-path.
        if (redirect_valid) begin
            buf_valid_d = 1'b0;
        end else if (buf_valid_q && !stall && !flush) begin
            buf_valid_d = 1'b0;
        end else if (word_live && (stall || flush)) begin
            buf_valid_d = 1'b1;
            buf_instr_d = imem_rdata;
            buf_pc_d    = pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC & 32'hFFFF_FFFC;
            buf_valid_q  <= 1'b0;
            buf_instr_q  <= NOP_INSTR;
            buf_pc_q     <= 32'd0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_valid_q  <= buf_valid_d;
            buf_instr_q  <= buf_instr_d;
            buf_pc_q     <= buf_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // The request is combinational, so it is masked for the whole time reset is held.
    assign imem_req        = fetch_req & ~reset;
    assign imem_addr       = pc_q;
    assign if_id_instr     = ifid_instr_q;
    assign if_id_pc        = ifid_pc_q;
    assign if_id_pc_plus_4 = ifid_pc4_q;
    assign if_id_valid     = ifid_valid_q;

endmodule

// File: tb/tb_rv32i_if_stage.sv
// Self-checking bench for rv32i_if_stage: directed scenarios plus randomized traffic
// checked against a queue-based fetch model.
module tb_rv32i_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus_4;
    logic        if_id_valid;

    int checks = 0;
    int errors = 0;

    rv32i_if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .if_id_pc_plus_4(if_id_pc_plus_4), .if_id_valid(if_id_valid)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a fixed scramble of the byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory environment state
    logic        mem_busy;
    logic [31:0] mem_addr_q;
    int          mem_wait;
    int          lat = 1;

    // Reference model: pc, list of outstanding fetches {live, addr}, skid list {instr, pc}
    logic [31:0] m_pc;
    logic [32:0] m_out[$];
    logic [63:0] m_skid[$];
    logic [31:0] exp_instr, exp_pc, exp_pc4, exp_addr;
    logic        exp_valid, exp_req, m_loaded;

    task automatic model_reset();
        m_pc = RESET_PC;
        m_out.delete();
        m_skid.delete();
        exp_instr = NOP; exp_pc = 32'd0; exp_pc4 = 32'd0; exp_valid = 1'b0;
        exp_req = 1'b0; exp_addr = 32'd0; m_loaded = 1'b0;
    endtask

    task automatic model_comb();
        exp_req  = (m_out.size() == 0) && !redirect_valid && (m_skid.size() == 0);
        exp_addr = m_pc;
    endtask

    task automatic model_update();
        logic        got_live;
        logic [32:0] o;
        logic [63:0] e;
        got_live = 1'b0;
        o        = 33'd0;
        m_loaded = 1'b0;
        if (imem_rvalid && m_out.size() > 0) begin
            o = m_out.pop_front();
            got_live = o[32] && !redirect_valid;
        end else if (redirect_valid && m_out.size() > 0) begin
            o = m_out.pop_front();
            o[32] = 1'b0;
            m_out.push_back(o);
        end
        if (flush) begin
            exp_instr = NOP;
            exp_valid = 1'b0;
        end else if (!stall) begin
            if (m_skid.size() > 0 && !redirect_valid) begin
                e = m_skid.pop_front();
                exp_instr = e[63:32]; exp_pc = e[31:0]; exp_pc4 = e[31:0] + 32'd4;
                exp_valid = 1'b1; m_loaded = 1'b1;
            end else if (got_live) begin
                exp_instr = mem_word(o[31:0]); exp_pc = o[31:0]; exp_pc4 = o[31:0] + 32'd4;
                exp_valid = 1'b1; m_loaded = 1'b1;
            end
        end
        if (redirect_valid) m_skid.delete();
        if (got_live && (stall || flush)) m_skid.push_back({mem_word(o[31:0]), o[31:0]});
        if (exp_req) m_out.push_back({1'b1, m_pc});
        if (redirect_valid) m_pc = redirect_pc & 32'hFFFF_FFFC;
        else if (got_live) m_pc = m_pc + 32'd4;
    endtask

    // Called at a falling edge: apply inputs and the memory response for this cycle.
    task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] t);
        stall = s; flush = f; redirect_valid = r; redirect_pc = t;
        if (mem_busy && mem_wait <= 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_addr_q);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (mem_busy) mem_wait--;
        end
        #1;
        model_comb();
    endtask

    // Clock edge: advance model and memory, return at the next falling edge.
    task automatic advance();
        logic        req_s;
        logic [31:0] addr_s;
        req_s  = imem_req;
        addr_s = imem_addr;
        model_update();
        @(posedge clk);
        if (imem_rvalid) mem_busy = 1'b0;
        if (req_s) begin
            mem_busy = 1'b1; mem_addr_q = addr_s; mem_wait = lat;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        imem_rvalid = 1'b0; imem_rdata = 32'd0; mem_busy = 1'b0; mem_wait = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        imem_rvalid = 1'b0; imem_rdata = 32'd0; mem_busy = 1'b0; mem_wait = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL reset_req: got %b expected 0", imem_req);
        end
        checks++;
        if (if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
            errors++; $display("FAIL reset_ifid: got valid=%b instr=%h expected valid=0 instr=%h", if_id_valid, if_id_instr, NOP);
        end
        checks++;
        if (if_id_pc !== 32'd0 || if_id_pc_plus_4 !== 32'd0) begin
            errors++; $display("FAIL reset_pc: got pc=%h pc4=%h expected 0/0", if_id_pc, if_id_pc_plus_4);
        end
        @(negedge clk);
        reset = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_sequential();
        do_reset(); lat = 1;
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0);
            if (k % 2 == 0) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'(k * 2)) begin
                    errors++; $display("FAIL seq_fetch k=%0d: got req=%b addr=%h expected req=1 addr=%h", k, imem_req, imem_addr, 32'(k * 2));
                end
            end
            if (k >= 2 && k % 2 == 0) begin
                checks++;
                if (if_id_valid !== 1'b1 || if_id_pc !== 32'((k / 2 - 1) * 4) ||
                    if_id_instr !== mem_word(32'((k / 2 - 1) * 4)) || if_id_pc_plus_4 !== 32'((k / 2) * 4)) begin
                    errors++; $display("FAIL seq_ifid k=%0d: got v=%b pc=%h instr=%h pc4=%h expected v=1 pc=%h instr=%h", k,
                        if_id_valid, if_id_pc, if_id_instr, if_id_pc_plus_4, 32'((k / 2 - 1) * 4), mem_word(32'((k / 2 - 1) * 4)));
                end
            end
            advance();
        end
        $display("test_sequential done");
    endtask

    task automatic test_stall();
        do_reset(); lat = 1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0); advance();
        end
        for (int k = 3; k < 7; k++) begin
            drive((k < 6), 1'b0, 1'b0, 32'd0);
            if (k >= 4) begin
                checks++;
                if (imem_req !== 1'b0 || if_id_pc !== 32'd0 || if_id_instr !== mem_word(32'd0)) begin
                    errors++; $display("FAIL stall_hold k=%0d: got req=%b pc=%h instr=%h expected req=0 pc=0 instr=%h", k, imem_req, if_id_pc, if_id_instr, mem_word(32'd0));
                end
            end
            advance();
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'd4 || if_id_instr !== mem_word(32'd4) || imem_req !== 1'b1 || imem_addr !== 32'd8) begin
            errors++; $display("FAIL stall_release: got v=%b pc=%h instr=%h req=%b addr=%h expected v=1 pc=4 instr=%h req=1 addr=8",
                if_id_valid, if_id_pc, if_id_instr, imem_req, imem_addr, mem_word(32'd4));
        end
        advance();
        drive(1'b0, 1'b0, 1'b0, 32'd0); advance();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (if_id_pc !== 32'd8 || if_id_instr !== mem_word(32'd8)) begin
            errors++; $display("FAIL stall_next: got pc=%h instr=%h expected pc=8 instr=%h", if_id_pc, if_id_instr, mem_word(32'd8));
        end
        advance();
        $display("test_stall done");
    endtask

    task automatic test_redirect_wait();
        do_reset(); lat = 3;
        drive(1'b0, 1'b0, 1'b0, 32'd0); advance();
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0103); advance();
        drive(1'b0, 1'b0, 1'b0, 32'd0); advance();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (imem_req !== 1'b0 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL redir_drop: got req=%b valid=%b expected 0/0", imem_req, if_id_valid);
        end
        advance();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL redir_addr: got req=%b addr=%h valid=%b expected req=1 addr=00000100 valid=0", imem_req, imem_addr, if_id_valid);
        end
        advance();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0); advance();
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0000_0100 || if_id_instr !== mem_word(32'h100)) begin
            errors++; $display("FAIL redir_first: got v=%b pc=%h instr=%h expected v=1 pc=00000100 instr=%h", if_id_valid, if_id_pc, if_id_instr, mem_word(32'h100));
        end
        advance();
        $display("test_redirect_wait done");
    endtask

    task automatic test_flush_redirect();
        do_reset(); lat = 1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0); advance();
        end
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0200); advance();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'd0) begin
            errors++; $display("FAIL flush_bubble: got v=%b instr=%h pc=%h expected v=0 instr=%h pc=0", if_id_valid, if_id_instr, if_id_pc, NOP);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin
            errors++; $display("FAIL flush_resume: got req=%b addr=%h expected req=1 addr=00000200", imem_req, imem_addr);
        end
        advance();
        drive(1'b0, 1'b0, 1'b0, 32'd0); advance();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0000_0200 || if_id_instr !== mem_word(32'h200)) begin
            errors++; $display("FAIL flush_target: got v=%b pc=%h instr=%h expected v=1 pc=00000200 instr=%h", if_id_valid, if_id_pc, if_id_instr, mem_word(32'h200));
        end
        advance();
        $display("test_flush_redirect done");
    endtask

    task automatic test_wrap();
        do_reset(); lat = 1;
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL wrap_noreq: got req=%b expected 0", imem_req);
        end
        advance();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_addr: got req=%b addr=%h expected req=1 addr=fffffffc", imem_req, imem_addr);
        end
        advance();
        drive(1'b0, 1'b0, 1'b0, 32'd0); advance();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (if_id_pc !== 32'hFFFF_FFFC || if_id_pc_plus_4 !== 32'd0 || if_id_instr !== mem_word(32'hFFFF_FFFC)) begin
            errors++; $display("FAIL wrap_ifid: got pc=%h pc4=%h instr=%h expected pc=fffffffc pc4=0 instr=%h", if_id_pc, if_id_pc_plus_4, if_id_instr, mem_word(32'hFFFF_FFFC));
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            errors++; $display("FAIL wrap_next: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
        end
        advance();
        $display("test_wrap done");
    endtask

    task automatic test_reset_in_wait();
        do_reset(); lat = 1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0); advance();
        end
        lat = 3;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (if_id_pc !== 32'd4 || if_id_valid !== 1'b1 || imem_addr !== 32'd8) begin
            errors++; $display("FAIL rstwait_pre: got pc=%h v=%b addr=%h expected pc=4 v=1 addr=8", if_id_pc, if_id_valid, imem_addr);
        end
        advance();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'd0 || if_id_pc_plus_4 !== 32'd0) begin
            errors++; $display("FAIL rstwait_async: got req=%b v=%b instr=%h pc=%h pc4=%h expected 0/0/%h/0/0",
                imem_req, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus_4, NOP);
        end
        mem_busy = 1'b0; imem_rvalid = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            errors++; $display("FAIL rstwait_restart: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
        advance();
        $display("test_reset_in_wait done");
    endtask

    task automatic test_random();
        logic s, f, r;
        logic [31:0] t;
        int txn;
        do_reset();
        txn = 0;
        for (int c = 0; c < 600; c++) begin
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 9) == 0);
            t = $urandom;
            lat = $urandom_range(1, 3);
            drive(s, f, r, t);
            checks++;
            if (imem_req !== exp_req || (exp_req && imem_addr !== exp_addr)) begin
                errors++; $display("FAIL rand_fetch c=%0d: got req=%b addr=%h expected req=%b addr=%h", c, imem_req, imem_addr, exp_req, exp_addr);
            end
            checks++;
            if (if_id_valid !== exp_valid || if_id_instr !== exp_instr || if_id_pc !== exp_pc || if_id_pc_plus_4 !== exp_pc4) begin
                errors++; $display("FAIL rand_ifid c=%0d: got v=%b instr=%h pc=%h pc4=%h expected v=%b instr=%h pc=%h pc4=%h",
                    c, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus_4, exp_valid, exp_instr, exp_pc, exp_pc4);
            end
            advance();
            if (m_loaded) begin
                txn++;
                $display("txn %0d: pc=%h instr=%h", txn, exp_pc, exp_instr);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_flush_redirect();
        test_wrap();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
